// File: rtl/jls_pkg.sv
// jls_pkg
// Shared definitions for the JPEG-LS scan controller slice.
//   JLS_PIX_W         : default pixel width
//   JLS_DIM_W         : default width of the column/row dimension registers
//   jls_scan_state_t  : scan sequencer states (IDLE, RUN, DRAIN)
package jls_pkg;

    localparam int JLS_PIX_W = 16;
    localparam int JLS_DIM_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } jls_scan_state_t;

endpackage

// File: rtl/jls_line_cnt.sv
// jls_line_cnt
// Column/row position counter for a raster-scanned frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to column 0 / row 0 (has priority over inc)
//   inc        : advance by one pixel
//   w_m1, h_m1 : frame width-1 and height-1
//   col, row   : current position
//   eol        : current column is the last one of the line
//   eof        : current position is the last pixel of the frame
module jls_line_cnt
    import jls_pkg::*;
#(
    parameter int DIM_W = JLS_DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIM_W-1:0] w_m1,
    input  logic [DIM_W-1:0] h_m1,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             eol,
    output logic             eof
);

    assign eol = (col == w_m1);
    assign eof = eol && (row == h_m1);

    // Wrapping to 0/0 after the final pixel leaves the counter ready for the
    // next frame without needing an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (eof) begin
                col <= '0;
                row <= '0;
            end else if (eol) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/jls_scan_ctrl.sv
// jls_scan_ctrl
// Frame/scan sequencer in front of the JPEG-LS context pipeline.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : one-cycle frame commands
//   cfg_width, cfg_height : frame size, latched on an accepted start
//   s_pixel/s_valid/s_ready : input pixel stream (valid/ready)
//   pixel_data, data_en   : registered pixel forwarding into the pipeline
//   pipe_en               : pipeline output-valid
//   out_sol/out_eol/out_eof : position tags for the current pipe_en beat
//   busy, done, err       : status to the system controller
module jls_scan_ctrl
    import jls_pkg::*;
#(
    parameter int PIX_W = JLS_PIX_W,
    parameter int DIM_W = JLS_DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [PIX_W-1:0] s_pixel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PIX_W-1:0] pixel_data,
    output logic             data_en,
    input  logic             pipe_en,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy,
    output logic             done,
    output logic             err
);

    jls_scan_state_t state, next_state;

    logic [DIM_W-1:0] w_m1, h_m1;
    logic [DIM_W-1:0] in_col, in_row, out_col, out_row;
    logic             in_eol, in_eof, out_eol_raw, out_eof_raw;
    logic             cfg_zero, start_ok, start_bad, accept, active, stray;

    // Abort overrides a coincident start, so neither a legal nor an illegal
    // start has any effect in that cycle.
    assign cfg_zero  = (cfg_width == '0) || (cfg_height == '0);
    assign start_ok  = start && !abort && (state == IDLE) && !cfg_zero;
    assign start_bad = start && !abort && (state == IDLE) && cfg_zero;

    assign s_ready = (state == RUN);
    assign accept  = s_valid && s_ready;
    assign active  = (state != IDLE);
    assign stray   = pipe_en && (state == IDLE);
    assign busy    = active;

    // Output tags are suppressed in IDLE, where pipe_en beats are ignored.
    assign out_sol = pipe_en && active && (out_col == '0);
    assign out_eol = pipe_en && active && out_eol_raw;
    assign out_eof = pipe_en && active && out_eof_raw;

    jls_line_cnt #(.DIM_W(DIM_W)) u_in_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok || abort),
        .inc   (accept),
        .w_m1  (w_m1),
        .h_m1  (h_m1),
        .col   (in_col),
        .row   (in_row),
        .eol   (in_eol),
        .eof   (in_eof)
    );

    jls_line_cnt #(.DIM_W(DIM_W)) u_out_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok || abort),
        .inc   (pipe_en && active),
        .w_m1  (w_m1),
        .h_m1  (h_m1),
        .col   (out_col),
        .row   (out_row),
        .eol   (out_eol_raw),
        .eof   (out_eof_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start_ok) next_state = RUN;
                RUN:     if (accept && in_eof) next_state = DRAIN;
                DRAIN:   if (out_eof) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The compare values are registered once per frame so the counters only
    // need equality checks against width-1/height-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_m1 <= '0;
            h_m1 <= '0;
        end else if (start_ok) begin
            w_m1 <= cfg_width - DIM_W'(1);
            h_m1 <= cfg_height - DIM_W'(1);
        end
    end

    // A pixel accepted in the same cycle as abort is not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= '0;
            data_en    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_en <= accept && !abort;
            if (accept) begin
                pixel_data <= s_pixel;
            end
            done <= (state == DRAIN) && out_eof && !abort;
            err  <= (err && !start_ok) || start_bad || stray;
        end
    end

endmodule

// File: tb/tb_jls_scan_ctrl.sv
// tb_jls_scan_ctrl
// Self-checking bench for jls_scan_ctrl: a table of command vectors for the
// start/abort/err corner cases, then model-checked frames with random pixel
// bubbles and a 4-cycle pipeline delay line, an abort mid-frame and a reset
// mid-frame.
module tb_jls_scan_ctrl;

    localparam int PIX_W = 16;
    localparam int DIM_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [DIM_W-1:0] cfg_width = '0;
    logic [DIM_W-1:0] cfg_height = '0;
    logic [PIX_W-1:0] s_pixel = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [PIX_W-1:0] pixel_data;
    logic             data_en;
    logic             pipe_en = 1'b0;
    logic             out_sol, out_eol, out_eof;
    logic             busy, done, err;

    jls_scan_ctrl #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .s_pixel    (s_pixel),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pixel_data (pixel_data),
        .data_en    (data_en),
        .pipe_en    (pipe_en),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: a frame is described only by its size, how many
    // pixels went in and how many beats came out.
    bit               m_active;
    bit               m_err;
    bit               m_de;
    bit               m_done;
    logic [PIX_W-1:0] m_pix;
    int               m_w, m_h, m_total, m_nin, m_nout;
    bit               dl[4];
    int               de_count;

    typedef struct {
        bit               start;
        bit               abort;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
        bit               pe;
        bit               exp_busy;
        bit               exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        m_active = 0; m_err = 0; m_de = 0; m_done = 0; m_pix = '0;
        m_w = 0; m_h = 0; m_total = 0; m_nin = 0; m_nout = 0;
        for (int i = 0; i < 4; i++) dl[i] = 0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        start = 0; abort = 0; s_valid = 0; pipe_en = 0;
        cfg_width = '0; cfg_height = '0;
        modelReset();
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_data_en", 32'(data_en), 0);
        checkOutput("rst_pixel_data", 32'(pixel_data), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_flags", 32'({out_sol, out_eol, out_eof}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        start = v.start; abort = v.abort; cfg_width = v.w; cfg_height = v.h;
        pipe_en = v.pe; s_valid = 0;
        @(negedge clk);
        start = 0; abort = 0; pipe_en = 0;
        checkOutput("tbl_busy", 32'(busy), 32'(v.exp_busy));
        checkOutput("tbl_err", 32'(err), 32'(v.exp_err));
    endtask

    // One clock: check registered outputs from the last edge, drive new
    // inputs, check the combinational outputs, then advance the model.
    task automatic step(input bit st, input bit ab, input logic [DIM_W-1:0] cw,
                        input logic [DIM_W-1:0] ch, input bit sv, input bit pe);
        bit exp_ready, acc, ok, bad;
        int col;
        @(negedge clk);
        checkOutput("data_en", 32'(data_en), 32'(m_de));
        checkOutput("pixel_data", 32'(pixel_data), 32'(m_pix));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("err", 32'(err), 32'(m_err));
        if (data_en === 1'b1) de_count++;
        start = st; abort = ab; cfg_width = cw; cfg_height = ch;
        s_valid = sv; s_pixel = PIX_W'($urandom); pipe_en = pe;
        #1;
        exp_ready = m_active && (m_nin < m_total);
        col = (m_w == 0) ? 0 : (m_nout % m_w);
        checkOutput("s_ready", 32'(s_ready), 32'(exp_ready));
        checkOutput("out_sol", 32'(out_sol), 32'(m_active && pe && col == 0));
        checkOutput("out_eol", 32'(out_eol), 32'(m_active && pe && col == m_w - 1));
        checkOutput("out_eof", 32'(out_eof), 32'(m_active && pe && m_nout == m_total - 1));
        acc    = sv && exp_ready;
        m_de   = acc && !ab;
        if (acc) m_pix = s_pixel;
        m_done = 0;
        if (ab) begin
            m_active = 0; m_nin = 0; m_nout = 0;
        end else if (!m_active) begin
            ok    = st && cw != 0 && ch != 0;
            bad   = st && (cw == 0 || ch == 0);
            m_err = (m_err && !ok) || bad || pe;
            if (ok) begin
                m_active = 1; m_w = int'(cw); m_h = int'(ch);
                m_total = m_w * m_h; m_nin = 0; m_nout = 0;
            end
        end else begin
            if (acc) m_nin++;
            if (pe) begin
                if (m_nout == m_total - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end
                m_nout++;
            end
        end
    endtask

    task automatic runFrame(input int w, input int h, input int pct, input int abort_after);
        bit finished, aborted, ab, sv;
        finished = 0; aborted = 0;
        de_count = 0;
        step(1, 0, DIM_W'(w), DIM_W'(h), 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (!m_active && !dl[0] && !dl[1] && !dl[2] && !dl[3]) begin
                finished = 1;
                break;
            end
            ab = (abort_after >= 0) && !aborted && m_active && (m_nin == abort_after);
            sv = ($urandom_range(99) < pct);
            step(0, ab, DIM_W'(w), DIM_W'(h), sv, dl[3]);
            dl[3] = dl[2]; dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = m_de;
            if (ab) begin
                aborted = 1;
                for (int i = 0; i < 4; i++) dl[i] = 0;
            end
        end
        if (!finished) checkOutput("frame_timeout", 0, 1);
        step(0, 0, '0, '0, 0, 0);
        if (abort_after < 0) checkOutput("data_en_count", de_count, w * h);
    endtask

    initial begin
        vecs[0] = '{1, 0, 12'd0, 12'd3, 0, 0, 1};
        vecs[1] = '{1, 0, 12'd3, 12'd0, 0, 0, 1};
        vecs[2] = '{0, 0, 12'd0, 12'd0, 0, 0, 1};
        vecs[3] = '{1, 0, 12'd2, 12'd2, 0, 1, 0};
        vecs[4] = '{1, 0, 12'd0, 12'd0, 0, 1, 0};
        vecs[5] = '{0, 1, 12'd0, 12'd0, 0, 0, 0};
        vecs[6] = '{1, 1, 12'd2, 12'd2, 0, 0, 0};
        vecs[7] = '{0, 0, 12'd0, 12'd0, 1, 0, 1};
        vecs[8] = '{1, 0, 12'd1, 12'd1, 0, 1, 0};
        vecs[9] = '{0, 1, 12'd0, 12'd0, 0, 0, 0};

        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        resetDut();
        runFrame(4, 2, 100, -1);
        runFrame(1, 1, 100, -1);
        runFrame(3, 3, 50, -1);
        runFrame(8, 8, 100, 20);
        runFrame(8, 8, 100, -1);
        for (int i = 0; i < 4; i++)
            runFrame($urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(100, 30), -1);

        // Reset asserted between clock edges in the middle of a frame.
        step(1, 0, 12'd4, 12'd4, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 12'd4, 12'd4, 1, 0);
        @(negedge clk);
        #2;
        resetDut();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
